// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   ZERO_ADDR               : address of the optional hardwired-zero register
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_mp.
// Selects between stored contents, same-cycle write data (bypass) and the
// hardwired zero, then registers data, valid and busy.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rd_en, rd_addr        read request and address
//   stored_data           current array contents at rd_addr
//   busy_now, busy_next   pre-edge and post-edge scoreboard bit at rd_addr
//   wr0_hit/addr/data     write port 0 (enable already qualified by zero-reg drop)
//   wr1_hit/addr/data     write port 1 (higher priority)
//   rd_data, rd_valid, rd_busy  registered outputs
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              busy_now,
  input  logic              busy_next,
  input  logic              wr0_hit,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_hit,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_busy
);

  logic              is_zero;
  logic [DATA_W-1:0] data_sel;
  logic              busy_sel;

  assign is_zero = ZERO_REG && (rd_addr == ADDR_W'(ZERO_ADDR));

  always_comb begin
    data_sel = stored_data;
    busy_sel = busy_now;
    if (BYPASS) begin
      // Port 1 is checked last so it overrides port 0 on a shared address.
      if (wr0_hit && (wr0_addr == rd_addr)) data_sel = wr0_data;
      if (wr1_hit && (wr1_addr == rd_addr)) data_sel = wr1_data;
      busy_sel = busy_next;
    end
    if (is_zero) begin
      data_sel = '0;
      busy_sel = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= data_sel;
        rd_busy <= busy_sel;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two prioritised write ports,
// NUM_RD registered read ports, optional write-to-read bypass, optional
// hardwired-zero register 0 and a per-register busy scoreboard.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rd_en/rd_addr               per-port read request, packed addresses
//   rd_data/rd_valid/rd_busy    per-port registered results
//   wr0_*/wr1_*                 write ports, wr1 wins on an address clash
//   claim_en/claim_addr         mark a register busy (result pending)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic wr0_hit, wr1_hit, claim_hit;

  // Accesses to the hardwired-zero register are dropped up front.
  assign wr0_hit   = wr0_en   && !(ZERO_REG && (wr0_addr   == ADDR_W'(ZERO_ADDR)));
  assign wr1_hit   = wr1_en   && !(ZERO_REG && (wr1_addr   == ADDR_W'(ZERO_ADDR)));
  assign claim_hit = claim_en && !(ZERO_REG && (claim_addr == ADDR_W'(ZERO_ADDR)));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr0_hit && (wr0_addr == ADDR_W'(i))) begin
        regs_d[i] = wr0_data;
        busy_d[i] = 1'b0;
      end
      if (wr1_hit && (wr1_addr == ADDR_W'(i))) begin
        regs_d[i] = wr1_data;
        busy_d[i] = 1'b0;
      end
      // A claim marks a new pending producer, so it beats a completing write.
      if (claim_hit && (claim_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en      (rd_en[k]),
      .rd_addr    (addr),
      .stored_data(regs_q[addr]),
      .busy_now   (busy_q[addr]),
      .busy_next  (busy_d[addr]),
      .wr0_hit    (wr0_hit),
      .wr0_addr   (wr0_addr),
      .wr0_data   (wr0_data),
      .wr1_hit    (wr1_hit),
      .wr1_addr   (wr1_addr),
      .wr1_data   (wr1_data),
      .rd_data    (rd_data[k*DATA_W +: DATA_W]),
      .rd_valid   (rd_valid[k]),
      .rd_busy    (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2,
// ZERO_REG=1, BYPASS=1): directed scenarios followed by randomized traffic,
// all checked against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic [NR-1:0]    rd_busy;
  logic             wr0_en;
  logic [AW-1:0]    wr0_addr;
  logic [DW-1:0]    wr0_data;
  logic             wr1_en;
  logic [AW-1:0]    wr1_addr;
  logic [DW-1:0]    wr1_data;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_REG(1'b1),
    .BYPASS  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_busy   (rd_busy),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .claim_en  (claim_en),
    .claim_addr(claim_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: register contents, pending flags, expected port outputs.
  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];
  logic [DW-1:0] e_data [NR];
  bit            e_busy [NR];
  bit            e_valid[NR];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    for (int k = 0; k < NR; k++) begin
      e_data[k]  = '0;
      e_busy[k]  = 1'b0;
      e_valid[k] = 1'b0;
    end
  endtask

  // Apply one clock edge to the model: update state first, then reads see the
  // updated state (bypass), with register 0 pinned to zero and never busy.
  task automatic model_edge();
    logic [AW-1:0] a;
    if (wr0_en && wr0_addr != 0) begin
      m_mem[wr0_addr]  = wr0_data;
      m_busy[wr0_addr] = 1'b0;
    end
    if (wr1_en && wr1_addr != 0) begin
      m_mem[wr1_addr]  = wr1_data;
      m_busy[wr1_addr] = 1'b0;
    end
    if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    for (int k = 0; k < NR; k++) begin
      e_valid[k] = rd_en[k];
      if (rd_en[k]) begin
        a         = rd_addr[k*AW +: AW];
        e_data[k] = (a == 0) ? '0 : m_mem[a];
        e_busy[k] = (a == 0) ? 1'b0 : m_busy[a];
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NR; k++) begin
      check_eq($sformatf("rd_valid%0d", k), DW'(rd_valid[k]), DW'(e_valid[k]));
      check_eq($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], e_data[k]);
      check_eq($sformatf("rd_busy%0d", k), DW'(rd_busy[k]), DW'(e_busy[k]));
    end
  endtask

  // Inputs are stable at the edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rd_en    = '0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    claim_en = 1'b0;
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst_n      = 1'b0;
    rd_en      = '0;
    rd_addr    = '0;
    wr0_en     = 1'b0;
    wr0_addr   = '0;
    wr0_data   = '0;
    wr1_en     = 1'b0;
    wr1_addr   = '0;
    wr1_data   = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // 1: every address reads zero, valid one cycle after each request.
    for (int a = 0; a < 32; a++) begin
      rd2(AW'(a), AW'(31 - a));
      step();
      check_eq("t1_valid", DW'(rd_valid), DW'(2'b11));
    end
    idle();
    step();
    check_eq("t1_valid_drop", DW'(rd_valid), '0);

    // 2: fill with 0x100+i; register 0 stays zero.
    for (int i = 0; i < 32; i++) begin
      wr0_en   = 1'b1;
      wr0_addr = AW'(i);
      wr0_data = DW'(32'h100 + i);
      step();
    end
    idle();
    for (int a = 0; a < 32; a++) begin
      rd2(AW'(a), AW'(a));
      step();
      check_eq("t2_data", rd_data[0 +: DW], (a == 0) ? '0 : DW'(32'h100 + a));
    end
    idle();

    // 3: simultaneous writes to one address, port 1 wins.
    wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hAAAA;
    wr1_en = 1'b1; wr1_addr = 5; wr1_data = 32'h5555;
    step();
    idle();
    rd2(5, 5);
    step();
    check_eq("t3_prio", rd_data[DW +: DW], 32'h5555);
    idle();

    // 4: read during write of the same address returns the new data.
    rd2(7, 7);
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'hDEAD;
    step();
    check_eq("t4_bypass", rd_data[0 +: DW], 32'hDEAD);
    idle();

    // 5: scoreboard claim / clear / claim-beats-write / zero never busy.
    claim_en = 1'b1; claim_addr = 9;
    step();
    idle();
    rd2(9, 9);
    step();
    check_eq("t5_claim", DW'(rd_busy[0]), 1);
    idle();
    wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'h99;
    step();
    idle();
    rd2(9, 9);
    step();
    check_eq("t5_clear", DW'(rd_busy[0]), 0);
    idle();
    claim_en = 1'b1; claim_addr = 9;
    wr1_en = 1'b1; wr1_addr = 9; wr1_data = 32'h77;
    step();
    idle();
    rd2(9, 9);
    step();
    check_eq("t5_claim_wins", DW'(rd_busy[1]), 1);
    check_eq("t5_claim_data", rd_data[DW +: DW], 32'h77);
    idle();
    claim_en = 1'b1; claim_addr = 0;
    rd2(0, 0);
    step();
    check_eq("t5_zero_busy", DW'(rd_busy[0]), 0);
    idle();

    // 6: asynchronous reset pulse between edges.
    rd2(5, 9);
    step();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("t6_async_data", rd_data, '0);
    #1 rst_n = 1'b1;
    rd2(5, 5);
    step();
    check_eq("t6_post_reset", rd_data[0 +: DW], '0);
    idle();

    // Random traffic, addresses narrowed so collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      rd_en      = NR'($urandom);
      rd_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wr0_en     = 1'($urandom);
      wr0_addr   = AW'($urandom_range(0, 7));
      wr0_data   = $urandom;
      wr1_en     = 1'($urandom);
      wr1_addr   = AW'($urandom_range(0, 7));
      wr1_data   = $urandom;
      claim_en   = ($urandom_range(0, 3) == 0);
      claim_addr = AW'($urandom_range(0, 7));
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
